// File: rtl/pipe_skid_reg_pkg.sv
// Shared Y86 encodings and occupancy states for the skid pipeline register.
package pipe_skid_reg_pkg;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] FNONE = 4'h0;
  // icode:ifun of a nop, presented downstream when a stage is squashed
  localparam logic [7:0] NOP_WORD = {INOP, FNONE};

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/pipe_skid_reg_cenrreg.sv
// Clock-enabled register with a synchronous reset to a caller-supplied value.
module pipe_skid_reg_cenrreg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] resetval,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset)       q <= resetval;
    else if (enable) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and bubble squash.
// Handshake: a word moves when valid & ready are both high at a rising edge; in_ready is a flop.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_WORD)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             bubble,
  output logic [1:0]       count
);

  occ_t             occ;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             accept;
  logic             drain;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_resetval;
  logic             squash;

  assign accept        = in_valid & in_ready_q;
  assign drain         = out_valid_q & out_ready;
  assign squash        = reset | bubble;
  assign main_resetval = reset ? RESET_VAL : BUBBLE_VAL;

  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    case (occ)
      OCC_EMPTY: main_en = accept;
      OCC_ONE: begin
        main_en = accept & drain;
        skid_en = accept & ~drain;
      end
      OCC_FULL: begin
        main_en = drain;
        main_d  = skid_q;
      end
      default: ;
    endcase
  end

  pipe_skid_reg_cenrreg #(.WIDTH(WIDTH)) u_main (
    .clock    (clock),
    .reset    (squash),
    .enable   (main_en),
    .resetval (main_resetval),
    .d        (main_d),
    .q        (out_data)
  );

  pipe_skid_reg_cenrreg #(.WIDTH(WIDTH)) u_skid (
    .clock    (clock),
    .reset    (squash),
    .enable   (skid_en),
    .resetval ('0),
    .d        (in_data),
    .q        (skid_q)
  );

  // Occupancy FSM; out_valid and in_ready are registered alongside the state.
  always_ff @(posedge clock) begin
    if (squash) begin
      occ         <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: if (accept) begin
          occ         <= OCC_ONE;
          out_valid_q <= 1'b1;
        end
        OCC_ONE: begin
          if (accept && !drain) begin
            occ        <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (drain && !accept) begin
            occ         <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        OCC_FULL: if (drain) begin
          occ        <= OCC_ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          occ         <= OCC_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!squash) assert (!(accept && occ == OCC_FULL));
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign count     = occ;

endmodule
